fpga_robots_game_beeper: RTL and testbench

Parametrised successor to the top-level single-channel attention counter. It accepts NREQ independent beep requests, each with its own duration in video frames and its own square-wave tone divider. It arbitrates them by fixed priority with pre-emption and a pending queue, and inserts a silent gap between back-to-back beeps. It drives the shared `attention` (visual flash) and `audio` (square wave) outputs that the top level currently produces with the 6-bit frame counter and the baud1 divider.

---
 rtl/fpga_robots_game_beeper_pkg.sv | 22 ++
 rtl/fpga_robots_game_beeper_tone.sv | 39 +++
 rtl/fpga_robots_game_beeper.sv | 166 ++++++++++++++++
 tb/tb_fpga_robots_game_beeper.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_robots_game_beeper_pkg.sv
// Shared definitions for the multi-channel beeper.
//   beep_state_t : arbiter state encoding (IDLE / PLAY / GAP)
//   highest_set  : priority encoder, index of the highest set bit (0 if none)
package fpga_robots_game_beeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } beep_state_t;

  // Widest request vector the priority encoder accepts; callers zero-extend.
  localparam int MAX_REQ = 32;

  function automatic int unsigned highest_set(input logic [MAX_REQ-1:0] v);
    highest_set = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) highest_set = i;
    end
  endfunction

endpackage

// File: rtl/fpga_robots_game_beeper_tone.sv
// Square-wave tone generator: toggles sq every div ticks while enabled.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the waveform (count and output back to 0)
//   enable   : advance on tick only while high
//   tick     : tone timebase pulse
//   div      : half-period in ticks; 0 holds the output low
//   sq       : square-wave output
module fpga_robots_game_beeper_tone #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic            tick,
  input  logic [DIVW-1:0] div,
  output logic            sq
);

  logic [DIVW-1:0] dcnt_reg;
  logic            sq_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      dcnt_reg <= '0;
      sq_reg   <= 1'b0;
    end else if (enable && tick && (div != '0)) begin
      if (dcnt_reg == div - DIVW'(1)) begin
        dcnt_reg <= '0;
        sq_reg   <= ~sq_reg;
      end else begin
        dcnt_reg <= dcnt_reg + DIVW'(1);
      end
    end
  end

  assign sq = sq_reg;

endmodule

// File: rtl/fpga_robots_game_beeper.sv
// Multi-channel beeper: arbitrates NREQ beep requests by fixed priority
// (higher index wins) with pre-emption, a pending set for lower-priority
// requests and a silent gap between back-to-back beeps.
//   clk, rst    : clock, synchronous active-high reset
//   framepulse  : frame strobe, beep durations count these
//   tick        : tone timebase strobe
//   req         : per-channel request strobes
//   req_frames  : per-channel duration (CTRW bits each), 0 = ignore request
//   req_div     : per-channel tone half-period in ticks (DIVW bits each)
//   mute        : silences audio only
//   attention   : high while a beep plays
//   audio       : square-wave tone
//   busy        : playing, in a gap, or something pending
//   active_id   : channel currently playing (valid while attention)
module fpga_robots_game_beeper
  import fpga_robots_game_beeper_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int CTRW = 6,
  parameter  int DIVW = 8,
  parameter  int GAPF = 3,
  localparam int AW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 framepulse,
  input  logic                 tick,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CTRW-1:0] req_frames,
  input  logic [NREQ*DIVW-1:0] req_div,
  input  logic                 mute,
  output logic                 attention,
  output logic                 audio,
  output logic                 busy,
  output logic [AW-1:0]        active_id
);

  localparam int GW = (GAPF > 0) ? $clog2(GAPF + 1) : 1;

  beep_state_t     state_reg;
  logic [AW-1:0]   cur_reg;
  logic [CTRW-1:0] cnt_reg;
  logic [GW-1:0]   gap_reg;
  logic [DIVW-1:0] div_reg;
  logic [NREQ-1:0] pend_reg;

  logic [CTRW-1:0] frames_arr [NREQ];
  logic [DIVW-1:0] div_arr    [NREQ];
  logic [NREQ-1:0] valid;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_chan
      assign frames_arr[gi] = req_frames[gi*CTRW +: CTRW];
      assign div_arr[gi]    = req_div[gi*DIVW +: DIVW];
      // Zero-length requests are invisible to the arbiter.
      assign valid[gi]      = req[gi] && (req_frames[gi*CTRW +: CTRW] != '0);
    end
  endgenerate

  logic            has_cand;
  logic [AW-1:0]   cand;
  logic [NREQ-1:0] pend_after;
  logic [AW-1:0]   hp_old;
  logic [AW-1:0]   hp_new;

  // Every valid strobe is first marked pending; whichever channel actually
  // starts this cycle has its bit cleared again below. This covers the
  // losers of a simultaneous strobe and non-pre-empting requests uniformly.
  assign has_cand   = |valid;
  assign cand       = AW'(highest_set(MAX_REQ'(valid)));
  assign pend_after = pend_reg | valid;
  assign hp_old     = AW'(highest_set(MAX_REQ'(pend_reg)));
  assign hp_new     = AW'(highest_set(MAX_REQ'(pend_after)));

  logic          load_en;
  logic [AW-1:0] load_id;

  // Decide whether a channel (re)starts this cycle and which one.
  always_comb begin
    load_en = 1'b0;
    load_id = cand;
    unique case (state_reg)
      IDLE: load_en = has_cand;
      PLAY: begin
        if (has_cand && (cand >= cur_reg)) begin
          load_en = 1'b1;
        end else if (framepulse && (cnt_reg <= CTRW'(1)) && (|pend_after) && (GAPF == 0)) begin
          load_en = 1'b1;
          load_id = hp_new;
        end
      end
      GAP: begin
        if (has_cand && (cand >= hp_old)) begin
          load_en = 1'b1;
        end else if (framepulse && (gap_reg <= GW'(1))) begin
          load_en = 1'b1;
          load_id = hp_new;
        end
      end
      default: ;
    endcase
  end

  logic [NREQ-1:0] load_mask;
  assign load_mask = NREQ'(1) << load_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cur_reg   <= '0;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      div_reg   <= '0;
      pend_reg  <= '0;
    end else begin
      pend_reg <= load_en ? (pend_after & ~load_mask) : pend_after;
      if (load_en) begin
        // Parameters are sampled now, at start time, not at request time.
        state_reg <= PLAY;
        cur_reg   <= load_id;
        cnt_reg   <= frames_arr[load_id];
        div_reg   <= div_arr[load_id];
      end else begin
        unique case (state_reg)
          PLAY: begin
            // A lower-priority strobe does not stall the running beep.
            if (framepulse) begin
              if (cnt_reg > CTRW'(1)) begin
                cnt_reg <= cnt_reg - CTRW'(1);
              end else if (|pend_after) begin
                state_reg <= GAP;
                gap_reg   <= GW'(GAPF);
              end else begin
                state_reg <= IDLE;
              end
            end
          end
          GAP: begin
            if (framepulse && (gap_reg > GW'(1))) gap_reg <= gap_reg - GW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  logic tone_sq;

  fpga_robots_game_beeper_tone #(
    .DIVW(DIVW)
  ) u_tone (
    .clk   (clk),
    .rst   (rst),
    .clear (load_en),
    .enable(state_reg == PLAY),
    .tick  (tick),
    .div   (div_reg),
    .sq    (tone_sq)
  );

  assign attention = (state_reg == PLAY);
  assign audio     = tone_sq & ~mute & (state_reg == PLAY);
  assign busy      = (state_reg != IDLE) || (|pend_reg);
  assign active_id = cur_reg;

endmodule

// File: tb/tb_fpga_robots_game_beeper.sv
// Self-checking bench for fpga_robots_game_beeper: directed scenarios plus a
// randomized run, all compared against a behavioural model of the beeper.
module tb_fpga_robots_game_beeper;

  localparam int NREQ = 4;
  localparam int CTRW = 6;
  localparam int DIVW = 8;
  localparam int GAPF = 3;
  localparam int AW   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 framepulse = 1'b0;
  logic                 tick = 1'b0;
  logic                 mute = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*CTRW-1:0] req_frames = '0;
  logic [NREQ*DIVW-1:0] req_div = '0;
  logic                 attention;
  logic                 audio;
  logic                 busy;
  logic [AW-1:0]        active_id;

  fpga_robots_game_beeper #(
    .NREQ(NREQ), .CTRW(CTRW), .DIVW(DIVW), .GAPF(GAPF)
  ) dut (
    .clk(clk), .rst(rst), .framepulse(framepulse), .tick(tick),
    .req(req), .req_frames(req_frames), .req_div(req_div), .mute(mute),
    .attention(attention), .audio(audio), .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fp_per = 20;   // 0 selects random framepulses
  int tk_per = 10;   // 0 selects random ticks

  // ---------------- behavioural model ----------------
  int fr_tab [NREQ];
  int dv_tab [NREQ];
  bit m_play, m_gap;
  int m_cur, m_rem, m_gapl, m_div, m_ticks;
  bit m_pend [NREQ];

  task automatic set_chan(input int i, input int f, input int d);
    fr_tab[i] = f;
    dv_tab[i] = d;
    req_frames[i*CTRW +: CTRW] = CTRW'(f);
    req_div[i*DIVW +: DIVW]    = DIVW'(d);
  endtask

  function automatic int m_highest_pend();
    int h = -1;
    for (int i = 0; i < NREQ; i++) if (m_pend[i]) h = i;
    return h;
  endfunction

  task automatic m_start(input int i);
    m_play  = 1'b1;
    m_gap   = 1'b0;
    m_cur   = i;
    m_rem   = fr_tab[i];
    m_div   = dv_tab[i];
    m_ticks = 0;
    m_pend[i] = 1'b0;
  endtask

  task automatic m_step(input logic [NREQ-1:0] r, input bit fp, input bit tk, input bit rs);
    int cand = -1;
    int hp;
    if (rs) begin
      m_play = 1'b0; m_gap = 1'b0; m_cur = 0; m_ticks = 0;
      for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
      return;
    end
    hp = m_highest_pend();
    if (m_play && tk) m_ticks++;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i] && fr_tab[i] != 0) begin
        cand = i;
        m_pend[i] = 1'b1;
      end
    end
    if (!m_play && !m_gap) begin
      if (cand >= 0) m_start(cand);
    end else if (m_play) begin
      if (cand >= 0 && cand >= m_cur) m_start(cand);
      else if (fp) begin
        if (m_rem > 1) m_rem--;
        else if (m_highest_pend() >= 0) begin
          if (GAPF > 0) begin
            m_play = 1'b0; m_gap = 1'b1; m_gapl = GAPF;
          end else m_start(m_highest_pend());
        end else m_play = 1'b0;
      end
    end else begin
      if (cand >= 0 && cand >= hp) m_start(cand);
      else if (fp) begin
        if (m_gapl > 1) m_gapl--;
        else m_start(m_highest_pend());
      end
    end
  endtask

  function automatic logic [AW+2:0] exp_vec();
    bit any = 1'b0;
    bit aud;
    for (int i = 0; i < NREQ; i++) any |= m_pend[i];
    aud = m_play && (m_div != 0) && !mute && (((m_ticks / (m_div == 0 ? 1 : m_div)) % 2) == 1);
    return {m_play, aud, (m_play || m_gap || any), (m_play ? AW'(m_cur) : AW'(0))};
  endfunction

  function automatic logic [AW+2:0] obs_vec();
    return {attention, audio, busy, (attention ? active_id : AW'(0))};
  endfunction

  // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic [NREQ-1:0] r, input bit force_fp, input bit rs);
    bit fp, tk;
    fp = force_fp || ((fp_per > 0) ? ((cyc % fp_per) == fp_per - 1) : ($urandom_range(0, 14) == 0));
    tk = (tk_per > 0) ? ((cyc % tk_per) == 0) : ($urandom_range(0, 2) == 0);
    req = r; framepulse = fp; tick = tk; rst = rs;
    if (r != '0 || rs)
      $display("txn cyc=%0d req=%b rst=%b fp=%b frames=%0d/%0d/%0d/%0d div=%0d/%0d/%0d/%0d",
               cyc, r, rs, fp, fr_tab[0], fr_tab[1], fr_tab[2], fr_tab[3],
               dv_tab[0], dv_tab[1], dv_tab[2], dv_tab[3]);
    m_step(r, fp, tk, rs);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    checks++;
    if ({attention, audio, busy, active_id} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b required 0", {attention, audio, busy, active_id});
    end
    step('0, 1'b0, 1'b0);
    checks++;
    if ({attention, audio, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got %b required 000", {attention, audio, busy});
    end
  endtask

  task automatic test_single();
    int frames_seen = 0;
    int last_tog = -1;
    bit att_prev, aud_prev;
    set_chan(0, 15, 4);
    fp_per = 20; tk_per = 10; mute = 1'b0;
    step(4'b0001, 1'b0, 1'b0);
    checks++;
    if (attention !== 1'b1 || active_id !== 2'd0) begin
      errors++;
      $display("FAIL single_rise: attention=%b id=%0d required 1/0", attention, active_id);
    end
    for (int k = 0; k < 360; k++) begin
      att_prev = attention; aud_prev = audio;
      step('0, 1'b0, 1'b0);
      if (att_prev && framepulse) frames_seen++;
      if (att_prev && attention && (audio != aud_prev)) begin
        if (last_tog >= 0) begin
          checks++;
          if (cyc - last_tog != 40) begin
            errors++;
            $display("FAIL single_halfperiod: got %0d cycles required 40", cyc - last_tog);
          end
        end
        last_tog = cyc;
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_cycle cyc=%0d: got %b required %b", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (frames_seen != 15 || attention !== 1'b0 || busy !== 1'b0 || audio !== 1'b0) begin
      errors++;
      $display("FAIL single_len: frames=%0d att=%b busy=%b audio=%b required 15/0/0/0",
               frames_seen, attention, busy, audio);
    end
  endtask

  task automatic test_preempt();
    int frames_seen = 0;
    bit att_prev;
    set_chan(0, 45, 3); set_chan(2, 15, 5);
    step(4'b0001, 1'b0, 1'b0);
    for (int k = 0; k < 200 && frames_seen < 5; k++) begin
      att_prev = attention;
      step('0, 1'b0, 1'b0);
      if (att_prev && framepulse) frames_seen++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL preempt_pre cyc=%0d: got %b required %b", cyc, obs_vec(), exp_vec());
      end
    end
    step(4'b0100, 1'b0, 1'b0);
    checks++;
    if (attention !== 1'b1 || active_id !== 2'd2) begin
      errors++;
      $display("FAIL preempt_switch: att=%b id=%0d required 1/2", attention, active_id);
    end
    frames_seen = 0;
    for (int k = 0; k < 360; k++) begin
      att_prev = attention;
      step('0, 1'b0, 1'b0);
      if (att_prev && framepulse) frames_seen++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL preempt_cycle cyc=%0d: got %b required %b", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (frames_seen != 15 || busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt_len: frames=%0d busy=%b required 15/0", frames_seen, busy);
    end
  endtask

  task automatic test_pending_gap();
    int gap_frames = 0;
    int ch1_frames = 0;
    bit att_prev, busy_prev;
    logic [AW-1:0] id_prev;
    set_chan(3, 10, 2); set_chan(1, 5, 6);
    step(4'b1000, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 420; k++) begin
      att_prev = attention; busy_prev = busy; id_prev = active_id;
      step('0, 1'b0, 1'b0);
      if (framepulse && busy_prev && !att_prev) gap_frames++;
      if (framepulse && att_prev && id_prev == 2'd1) ch1_frames++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL gap_cycle cyc=%0d: got %b required %b", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (gap_frames != GAPF || ch1_frames != 5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap_len: gap=%0d ch1=%0d busy=%b required %0d/5/0", gap_frames, ch1_frames, busy, GAPF);
    end
  endtask

  task automatic test_simultaneous();
    int ch2_frames = 0;
    int ch1_frames = 0;
    bit att_prev;
    logic [AW-1:0] id_prev;
    set_chan(2, 8, 3); set_chan(1, 4, 0);
    step(4'b0110, 1'b1, 1'b0);
    checks++;
    if (attention !== 1'b1 || active_id !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_start: att=%b id=%0d busy=%b required 1/2/1", attention, active_id, busy);
    end
    for (int k = 0; k < 420; k++) begin
      att_prev = attention; id_prev = active_id;
      step('0, 1'b0, 1'b0);
      if (framepulse && att_prev && id_prev == 2'd2) ch2_frames++;
      if (framepulse && att_prev && id_prev == 2'd1) ch1_frames++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL simul_cycle cyc=%0d: got %b required %b", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (ch2_frames != 8 || ch1_frames != 4) begin
      errors++;
      $display("FAIL simul_len: ch2=%0d ch1=%0d required 8/4", ch2_frames, ch1_frames);
    end
  endtask

  task automatic test_edges();
    bit aud_seen, att_seen, busy_seen;
    // Zero-length request is ignored.
    set_chan(1, 0, 3);
    busy_seen = 1'b0;
    step(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      busy_seen |= busy;
      step('0, 1'b0, 1'b0);
    end
    checks++;
    if (busy_seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_frames: busy seen=%b required 0", busy_seen);
    end
    // div = 0: silent beep, then mute with a fast tone.
    for (int pass = 0; pass < 2; pass++) begin
      set_chan(0, 3, pass == 0 ? 0 : 1);
      mute = (pass == 1);
      aud_seen = 1'b0; att_seen = 1'b0;
      step(4'b0001, 1'b0, 1'b0);
      for (int k = 0; k < 100; k++) begin
        att_seen |= attention;
        aud_seen |= audio;
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL edge_cycle pass=%0d cyc=%0d: got %b required %b", pass, cyc, obs_vec(), exp_vec());
        end
        step('0, 1'b0, 1'b0);
      end
      checks++;
      if (!att_seen || aud_seen) begin
        errors++;
        $display("FAIL silent_beep pass=%0d: att=%b audio=%b required 1/0", pass, att_seen, aud_seen);
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit busy_seen = 1'b0;
    set_chan(3, 20, 2); set_chan(1, 5, 2);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    checks++;
    if ({attention, audio, busy, active_id} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %b required 0", {attention, audio, busy, active_id});
    end
    for (int k = 0; k < 100; k++) begin
      step('0, 1'b0, 1'b0);
      busy_seen |= busy | attention;
    end
    checks++;
    if (busy_seen) begin
      errors++;
      $display("FAIL reset_resume: busy/attention seen after reset, required none");
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    bit rs;
    fp_per = 0; tk_per = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0)
        set_chan($urandom_range(0, NREQ-1), $urandom_range(0, 6), $urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      r  = ($urandom_range(0, 7) == 0) ? NREQ'($urandom_range(1, (1 << NREQ) - 1)) : '0;
      rs = ($urandom_range(0, 499) == 0);
      step(r, 1'b0, rs);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle cyc=%0d: got %b required %b", cyc, obs_vec(), exp_vec());
      end
    end
    mute = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_chan(i, 0, 0);
    m_play = 1'b0; m_gap = 1'b0; m_cur = 0; m_rem = 0; m_gapl = 0; m_div = 0; m_ticks = 0;
    for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_preempt();
    test_pending_gap();
    test_simultaneous();
    test_edges();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
